// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment readback path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seg_pkg;

  // Active-low segment patterns, bit6=a down to bit0=g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Nibble reported for blank or unrecognised digits
  localparam logic [3:0] NIBBLE_FILL = 4'hF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/seg_pattern_dec.sv
// Inverse 7-segment decode: pattern -> {nibble, blank, err}.
// Latency: purely combinational.
// Backpressure: none.
module seg_pattern_dec
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  // Table lookup; anything not in the glyph set is flagged as an error
  always_comb begin
    nibble = NIBBLE_FILL;
    blank  = 1'b0;
    err    = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus, one frame at a time.
// Latency: last digit stable at edge N -> accepted at N+1 -> out_valid at N+2.
// Backpressure: one-frame output holding register; a frame completing while held and not drained is dropped with an overrun pulse.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    overrun
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [SW-1:0]           samp_now, samp_q;
  logic [CW-1:0]           cnt_q, cnt_nxt;
  logic                    an_ok;
  logic                    acc_nxt, acc_pend_q;
  logic [SW-1:0]           acc_samp_q;
  logic [NUM_DIGITS-1:0]   acc_an;
  logic [3:0]              dec_nib;
  logic                    dec_blank, dec_err;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [4*NUM_DIGITS-1:0] slot_dig_q;
  logic [NUM_DIGITS-1:0]   slot_blank_q, slot_err_q;
  logic                    frame_done;
  out_state_t              state_q, state_nxt;
  logic                    load, drop;

  assign samp_now   = {an_in, seg_in};
  assign an_ok      = $onehot(~an_in);
  assign acc_an     = acc_samp_q[SW-1:7];
  assign frame_done = (mask_q == '1);
  assign out_valid  = (state_q == FULL);

  // Stability count of the incoming sample; restarts at 1 on a new legal sample
  always_comb begin
    cnt_nxt = '0;
    if (an_ok) begin
      if (samp_now == samp_q)
        cnt_nxt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      else
        cnt_nxt = CW'(1);
    end
  end

  // Accept only on the transition into the threshold, never while saturated
  assign acc_nxt = (cnt_nxt == CNT_MAX) && (cnt_q != CNT_MAX);

  seg_pattern_dec u_dec (
    .pattern (acc_samp_q[6:0]),
    .nibble  (dec_nib),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  // Sample register, counter and the one-cycle accept pipeline stage
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '1;
      cnt_q      <= '0;
      acc_pend_q <= 1'b0;
      acc_samp_q <= '1;
    end else begin
      samp_q     <= samp_now;
      cnt_q      <= cnt_nxt;
      acc_pend_q <= acc_nxt;
      if (acc_nxt)
        acc_samp_q <= samp_now;
    end
  end

  // Digit slots and capture mask; a full mask is consumed (cleared) the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q       <= '0;
      slot_dig_q   <= '1;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
    end else begin
      mask_q <= (frame_done ? '0 : mask_q) | (acc_pend_q ? ~acc_an : '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (acc_pend_q && !acc_an[i]) begin
          slot_dig_q[4*i +: 4] <= dec_nib;
          slot_blank_q[i]      <= dec_blank;
          slot_err_q[i]        <= dec_err;
        end
      end
    end
  end

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_nxt;
  end

  // Output FSM: load a completed frame when empty or draining, drop it otherwise
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    drop      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (frame_done) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (frame_done) load = 1'b1;
          else            state_nxt = EMPTY;
        end else if (frame_done) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Output holding registers and overrun pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_out <= '1;
      blank_out  <= '0;
      err_out    <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= drop;
      if (load) begin
        digits_out <= slot_dig_q;
        blank_out  <= slot_blank_q;
        err_out    <= slot_err_q;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
module tb_seg_scan_reader;
  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_in;
  logic [ND-1:0] an_in;
  logic          out_valid;
  logic          out_ready;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] blank_out;
  logic [ND-1:0] err_out;
  logic          overrun;

  always #5 clk = ~clk;

  seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .digits_out (digits_out),
    .blank_out  (blank_out),
    .err_out    (err_out),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [4*ND-1:0] dig;
    logic [ND-1:0]   blk;
    logic [ND-1:0]   err;
  } frame_t;

  frame_t sb_q[$];
  frame_t mon_f;
  int checks = 0, errors = 0;
  int frames_pushed = 0, frames_seen = 0;
  int overruns_exp = 0, overruns_seen = 0;
  bit drop_next = 0;

  // Reference model: per-digit captured values and which digits are present
  logic [3:0] m_dig [ND];
  bit         m_blk [ND];
  bit         m_err [ND];
  bit         m_have[ND];

  // Glyph table: entry k is the pattern for hex value k
  logic [6:0] pat_tab [13] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ND; i++) m_have[i] = 0;
  endtask

  task automatic model_accept(int idx, logic [6:0] seg);
    frame_t f;
    bit all;
    m_dig[idx] = 4'hF;
    m_blk[idx] = 0;
    m_err[idx] = 0;
    if (seg == 7'b1111111) m_blk[idx] = 1;
    else begin
      m_err[idx] = 1;
      for (int k = 0; k < 13; k++)
        if (pat_tab[k] == seg) begin
          m_dig[idx] = 4'(k);
          m_err[idx] = 0;
        end
    end
    m_have[idx] = 1;
    all = 1;
    for (int i = 0; i < ND; i++) all = all & m_have[i];
    if (all) begin
      for (int i = 0; i < ND; i++) begin
        f.dig[4*i +: 4] = m_dig[i];
        f.blk[i] = m_blk[i];
        f.err[i] = m_err[i];
      end
      model_clear();
      if (drop_next) begin
        drop_next = 0;
        overruns_exp++;
      end else begin
        sb_q.push_back(f);
        frames_pushed++;
      end
    end
  endtask

  // Present one pattern on the bus for 'hold' cycles; prediction is made once the
  // threshold is reached so it is queued before the DUT can present the frame
  task automatic dwell(logic [ND-1:0] an, logic [6:0] seg, int hold);
    int idx;
    an_in  = an;
    seg_in = seg;
    if ($countones(~an) == 1 && hold >= SC) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (!an[i]) idx = i;
      repeat (SC) @(negedge clk);
      model_accept(idx, seg);
      repeat (hold - SC) @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
    end
  endtask

  task automatic digit(int idx, logic [6:0] seg, int hold);
    logic [ND-1:0] an;
    an = ~(ND'(1) << idx);
    dwell(an, seg, hold);
  endtask

  task automatic idle(int n);
    dwell('1, 7'b1111111, n);
  endtask

  task automatic flush(string name);
    idle(4);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check({name, "_flush"}, sb_q.size(), 0);
  endtask

  task automatic apply_reset(string name);
    idle(3);
    rst = 1;
    repeat (2) @(negedge clk);
    model_clear();
    rst = 0;
    check({name, "_rst_valid"},   out_valid,  0);
    check({name, "_rst_digits"},  digits_out, 16'hFFFF);
    check({name, "_rst_blank"},   blank_out,  0);
    check({name, "_rst_err"},     err_out,    0);
    check({name, "_rst_overrun"}, overrun,    0);
  endtask

  // Monitor: pops expected frames on each handshake, counts overrun pulses
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (overrun) overruns_seen++;
        if (out_valid && out_ready) begin
          frames_seen++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got digits %h with no frame expected", digits_out);
          end else begin
            mon_f = sb_q.pop_front();
            check("frame_digits", digits_out, mon_f.dig);
            check("frame_blank",  blank_out,  mon_f.blk);
            check("frame_err",    err_out,    mon_f.err);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; out_ready = 1; an_in = '1; seg_in = '1;
    model_clear();
    repeat (2) @(negedge clk);
    apply_reset("t0");

    // 1: basic scan 0..3
    for (int i = 0; i < ND; i++) digit(i, pat_tab[i], 4);
    flush("t1");
    check("t1_frames", frames_seen, 1);
    apply_reset("t1");

    // 2: digit 2 held one cycle short twice, then long enough
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < ND; i++) digit(i, pat_tab[i], (i == 2) ? 3 : 4);
    idle(6);
    check("t2_no_frame", frames_seen, frames_pushed);
    check("t2_valid_low", out_valid, 0);
    for (int i = 0; i < ND; i++) digit(i, pat_tab[i], 4);
    flush("t2");
    check("t2_frames", frames_seen, frames_pushed);
    apply_reset("t2");

    // 3: A, b, C, blank
    digit(0, pat_tab[10], 4);
    digit(1, pat_tab[11], 5);
    digit(2, pat_tab[12], 4);
    digit(3, 7'b1111111, 6);
    flush("t3");
    apply_reset("t3");

    // 4: illegal pattern on digit 1, two anodes low mid-frame
    digit(0, pat_tab[5], 4);
    digit(1, 7'b1111110, 4);
    dwell(4'b1100, pat_tab[8], 10);
    digit(2, pat_tab[7], 4);
    digit(3, pat_tab[9], 4);
    flush("t4");
    apply_reset("t4");

    // 5: backpressure and overrun
    out_ready = 0;
    for (int i = 0; i < ND; i++) digit(i, pat_tab[4 - i], 4);
    drop_next = 1;
    for (int i = 0; i < ND; i++) digit(i, pat_tab[8 - i], 4);
    idle(5);
    check("t5_held_valid",  out_valid,  1);
    check("t5_held_digits", digits_out, 16'h1234);
    check("t5_overrun_cnt", overruns_seen, 1);
    out_ready = 1;
    @(negedge clk);
    check("t5_valid_drop", out_valid, 0);
    flush("t5");
    apply_reset("t5");

    // 6: reset mid-frame, then a fresh frame
    digit(0, pat_tab[1], 4);
    digit(1, pat_tab[2], 4);
    apply_reset("t6");
    for (int i = 0; i < ND - 1; i++) digit(i, pat_tab[6 + i], 4);
    idle(6);
    check("t6_partial_no_valid", out_valid, 0);
    digit(ND - 1, pat_tab[9], 4);
    flush("t6");

    // Randomised scans with revisits, short dwells and stray patterns
    apply_reset("rnd");
    for (int fr = 0; fr < 30; fr++) begin
      for (int i = 0; i < ND; i++) begin
        logic [6:0] pat;
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 13)       pat = pat_tab[r];
        else if (r == 13) pat = 7'b1111111;
        else              pat = 7'($urandom);
        digit(i, pat, int'($urandom_range(2, 7)));
        if (i > 0 && i < ND - 1 && $urandom_range(0, 3) == 0)
          digit(i - 1, pat_tab[$urandom_range(0, 12)], int'($urandom_range(3, 6)));
      end
    end
    flush("rnd");

    check("final_frames",   frames_seen,   frames_pushed);
    check("final_overruns", overruns_seen, overruns_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
